// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ID-stage hazard detection unit.
package pipeline_pkg;

    typedef enum logic [1:0] {
        HDU_IDLE,
        HDU_LOAD_STALL,
        HDU_FLUSH
    } hdu_state_e;

    localparam logic [3:0] REG_PC = 4'hF;

    typedef struct packed {
        logic ctrl_nop;
        logic pc_load_en;
        logic ifid_load_en;
        logic ifid_flush;
    } hdu_ctrl_t;

    localparam hdu_ctrl_t CTRL_PASS  = '{ctrl_nop: 1'b0, pc_load_en: 1'b1, ifid_load_en: 1'b1, ifid_flush: 1'b0};
    localparam hdu_ctrl_t CTRL_RESET = CTRL_PASS;
    localparam hdu_ctrl_t CTRL_STALL = '{ctrl_nop: 1'b1, pc_load_en: 1'b0, ifid_load_en: 1'b0, ifid_flush: 1'b0};
    localparam hdu_ctrl_t CTRL_FLUSH = '{ctrl_nop: 1'b1, pc_load_en: 1'b1, ifid_load_en: 1'b1, ifid_flush: 1'b1};

    function automatic logic src_match(input logic used, input logic [3:0] src, input logic [3:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hdu_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module hdu_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard detection: load-use, status-flag and taken-branch bubbles,
// with a small FSM stretching load stalls and branch flushes over several cycles.
module hazard_detect_unit
    import pipeline_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [3:0]       id_rn,
    input  logic             id_rn_used,
    input  logic [3:0]       id_rm,
    input  logic             id_rm_used,
    input  logic [3:0]       id_rd,
    input  logic             id_rd_used,
    input  logic             id_cond_exec,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [3:0]       ex_rd,
    input  logic             ex_s_bit,
    input  logic             ex_branch_taken,
    output logic             ctrl_nop,
    output logic             pc_load_en,
    output logic             ifid_load_en,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] bubble_count
);

    // Cycles still to be spent in LOAD_STALL / FLUSH after the entry cycle.
    localparam logic [2:0] LOAD_REM  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_REM = 3'(FLUSH_CYCLES - 1);

    hdu_state_e state_q, state_d;
    logic [2:0] remain_q, remain_d;
    hdu_ctrl_t  ctrl;
    logic       lu_haz;
    logic       flag_haz;
    logic       br;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        lu_haz = id_valid && ex_mem_read && ex_reg_write && (ex_rd != REG_PC) &&
                 (src_match(id_rn_used, id_rn, ex_rd) ||
                  src_match(id_rm_used, id_rm, ex_rd) ||
                  src_match(id_rd_used, id_rd, ex_rd));
        flag_haz = id_valid && id_cond_exec && ex_s_bit;
        br       = ex_branch_taken;

        state_d  = state_q;
        remain_d = remain_q;
        ctrl     = CTRL_PASS;

        unique case (state_q)
            HDU_IDLE: begin
                if (br) begin
                    ctrl = CTRL_FLUSH;
                    if (FLUSH_REM != 3'd0) begin
                        state_d  = HDU_FLUSH;
                        remain_d = FLUSH_REM;
                    end
                end else if (lu_haz) begin
                    ctrl = CTRL_STALL;
                    if (LOAD_REM != 3'd0) begin
                        state_d  = HDU_LOAD_STALL;
                        remain_d = LOAD_REM;
                    end
                end else if (flag_haz) begin
                    ctrl = CTRL_STALL;
                end
            end

            HDU_LOAD_STALL: begin
                if (br) begin
                    // A taken branch squashes the stalled instruction anyway.
                    ctrl     = CTRL_FLUSH;
                    state_d  = (FLUSH_REM != 3'd0) ? HDU_FLUSH : HDU_IDLE;
                    remain_d = FLUSH_REM;
                end else begin
                    ctrl = CTRL_STALL;
                    if (remain_q <= 3'd1) begin
                        state_d = HDU_IDLE;
                    end else begin
                        remain_d = remain_q - 3'd1;
                    end
                end
            end

            HDU_FLUSH: begin
                ctrl = CTRL_FLUSH;
                if (br) begin
                    state_d  = (FLUSH_REM != 3'd0) ? HDU_FLUSH : HDU_IDLE;
                    remain_d = FLUSH_REM;
                end else if (remain_q <= 3'd1) begin
                    state_d = HDU_IDLE;
                end else begin
                    remain_d = remain_q - 3'd1;
                end
            end

            default: state_d = HDU_IDLE;
        endcase

        if (reset) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HDU_IDLE;
            remain_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    assign ctrl_nop     = ctrl.ctrl_nop;
    assign pc_load_en   = ctrl.pc_load_en;
    assign ifid_load_en = ctrl.ifid_load_en;
    assign ifid_flush   = ctrl.ifid_flush;

    hdu_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (ctrl.ctrl_nop),
        .count_o (bubble_count)
    );

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Generates the control-hazard/bubble request consumed by the control-unit bubble mux in the ID stage. When asserted, that mux zeroes all control signals, giving a NOP into ID/EX.
- Also drives PC and IF/ID register load enables and the IF/ID flush for the 5-stage ARM pipeline.
- Detects three hazards:
  - load-use data hazards
  - condition-flag (status bit) hazards
  - taken-branch control hazards
- A small FSM holds multi-cycle stalls and flushes.

Parameters:
- LOAD_STALL_CYCLES, 1, total bubble cycles inserted for a load-use hazard (1..7).
- FLUSH_CYCLES, 1, total bubble/flush cycles after a taken branch resolves in EX (1..7).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rn  in  4  ID source register Rn.
- id_rn_used  in  1  instruction reads Rn.
- id_rm  in  4  ID source register Rm.
- id_rm_used  in  1  instruction reads Rm.
- id_rd  in  4  ID store-data register.
- id_rd_used  in  1  instruction reads Rd (store).
- id_cond_exec  in  1  ID condition field is not AL.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_rd  in  4  EX destination register.
- ex_s_bit  in  1  EX instruction updates the status bits.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- ctrl_nop  out  1  bubble request to the control-unit mux (1 = zero controls).
- pc_load_en  out  1  PC register load enable.
- ifid_load_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register synchronous clear.
- bubble_count  out  CNT_W  saturating count of cycles with ctrl_nop=1.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0, bubble_count=0.
  - While reset is high, outputs are ctrl_nop=0, pc_load_en=1, ifid_load_en=1, ifid_flush=0.
- States: IDLE, LOAD_STALL, FLUSH. Internal 3-bit down-counter `remain`.
- Hazard terms, evaluated combinationally in the same cycle (zero latency):
  - lu_haz = id_valid & ex_mem_read & ex_reg_write & ex_rd!=4'hF & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd) | (id_rd_used & id_rd==ex_rd)).
  - flag_haz = id_valid & id_cond_exec & ex_s_bit.
  - br = ex_branch_taken.
- Priority, highest first: br, lu_haz, flag_haz.
- IDLE:
  - br: ctrl_nop=1, ifid_flush=1, pc_load_en=1, ifid_load_en=1. If FLUSH_CYCLES>1, go to FLUSH with remain=FLUSH_CYCLES-1; otherwise stay in IDLE.
  - lu_haz: ctrl_nop=1, pc_load_en=0, ifid_load_en=0. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with remain=LOAD_STALL_CYCLES-1.
  - flag_haz: ctrl_nop=1, pc_load_en=0, ifid_load_en=0 for exactly 1 cycle; stay in IDLE.
  - No hazard: pass-through values (0,1,1,0).
- LOAD_STALL:
  - Outputs: ctrl_nop=1, pc_load_en=0, ifid_load_en=0.
  - remain decrements each cycle; when it reaches 1, go to IDLE next cycle.
  - br in this state aborts the stall: FLUSH outputs that cycle; go to FLUSH with remain=FLUSH_CYCLES-1, or to IDLE if that value is 0.
- FLUSH:
  - Outputs: ctrl_nop=1, ifid_flush=1, pc_load_en=1, ifid_load_en=1.
  - remain decrements; go to IDLE when it reaches 1.
  - A new br restarts remain at FLUSH_CYCLES-1.
  - lu_haz and flag_haz are ignored, because the ID contents are being flushed.
- bubble_count increments on each clock edge where ctrl_nop=1 and reset=0. It saturates at all-ones and never wraps.
- Register 15 (PC) as ex_rd never causes a load-use stall.
- Reset asserted mid-stall or mid-flush aborts immediately to IDLE with the reset output values.
- All 4-bit compares are exact equality. There is no width extension.

Decomposition:
- Shared package pipeline_pkg:
  - state enum HDU_IDLE/HDU_LOAD_STALL/HDU_FLUSH
  - REG_PC=4'hF
  - reset/pass-through output constants
- One natural sub-module: hdu_sat_counter, the CNT_W saturating counter with enable. Everything else stays in one always_ff FSM plus one always_comb output/hazard block.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=3; id_rn_used=1, id_rn=3 (LOAD_STALL_CYCLES=1) -> one cycle of ctrl_nop=1, pc_load_en=0, ifid_load_en=0; next cycle all pass-through; bubble_count=1.
- Load to PC: same as above with ex_rd=4'hF, id_rn=4'hF -> no stall, ctrl_nop=0.
- Flag hazard: ex_s_bit=1, id_cond_exec=1, id_valid=1 -> 1-cycle stall. Repeat with id_valid=0 -> no stall.
- Taken branch (FLUSH_CYCLES=2): ex_branch_taken pulse -> ctrl_nop=1 and ifid_flush=1 for 2 cycles, pc_load_en=1 throughout; load-use inputs asserted during the second cycle are ignored.
- Branch during load stall (LOAD_STALL_CYCLES=3): branch in the 2nd stall cycle -> that cycle shows ifid_flush=1, pc_load_en=1; FLUSH completes, then IDLE.
- Reset mid-FLUSH: assert reset asynchronously -> outputs return to 0/1/1/0 immediately and bubble_count=0. Saturation: preload via 2^CNT_W continuous bubbles (CNT_W=4) -> bubble_count holds at 15.
